// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and default framing parameters.
// Also intended for use by the transmitter.
package uart_pkg;

  localparam int unsigned OS_DEF        = 16;
  localparam int unsigned DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// The reset value is a parameter so an idle-high line does not look like a start bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff_q <= {2{RST_VAL}};
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled mid-bit sampling, LSB-first deserialiser,
// and a valid/ready holding register with frame and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OS        = OS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 os_tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_err_o,
  output logic                 busy_o
);

  localparam int unsigned TW = $clog2(OS);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rxs;
  uart_state_e          state_q;
  logic [TW-1:0]        tcnt_q;
  logic [BW-1:0]        bcnt_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, frame_err_q, overrun_err_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rxs)
  );

  // LSB arrives first, so each new sample enters at the top and shifts down.
  assign shift_d = {rxs, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      bcnt_q        <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
      if (os_tick_i) begin
        case (state_q)
          IDLE: begin
            if (!rxs) begin
              state_q <= START;
              tcnt_q  <= '0;
            end
          end
          START: begin
            if (tcnt_q == T_HALF) begin
              tcnt_q  <= '0;
              bcnt_q  <= '0;
              state_q <= rxs ? IDLE : DATA;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          DATA: begin
            if (tcnt_q == T_FULL) begin
              shift_q <= shift_d;
              tcnt_q  <= '0;
              bcnt_q  <= bcnt_q + 1'b1;
              if (bcnt_q == B_LAST) state_q <= STOP;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          STOP: begin
            // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
            if (tcnt_q == T_FULL) begin
              state_q <= IDLE;
              tcnt_q  <= '0;
              if (!rxs) begin
                frame_err_q <= 1'b1;
              end else if (!rx_valid_q || rx_ready_i) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_err_q <= 1'b1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_err_q;
  assign busy_o        = (state_q != IDLE);

endmodule
